// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame constants and keyboard
// command bytes used by both the transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_IDLE
    } ps2TxState_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam logic PS2_ACK = 1'b0;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser plus falling-edge detector for one PS/2 pad line (clock or data).
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iLine,
    output logic oLine,
    output logic oFall
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   prevLine;

    // NOTE: the chain resets to the idle (pulled-up) level so leaving reset never
    // fabricates a falling edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            syncReg  <= '1;
            prevLine <= 1'b1;
        end else begin
            syncReg  <= {syncReg[SYNC_STAGES-2:0], iLine};
            prevLine <= syncReg[SYNC_STAGES-1];
        end
    end

    assign oLine = syncReg[SYNC_STAGES-1];
    assign oFall = prevLine & ~oLine;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked
// serialisation of one byte, ACK check and per-edge timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iStart,
    input  logic       clk_kb,
    input  logic       data_kb,
    output logic       oClk_kb_low,
    output logic       oData_kb_low,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int TIMER_W = $clog2(maxOf3(INHIBIT_CYCLES, RTS_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RTS_LAST     = TIMER_W'(RTS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         LAST_BIT     = 4'(PS2_FRAME_BITS - 2);

    ps2TxState_t                 state;
    logic [PS2_FRAME_BITS-2:0]   shiftReg;
    logic [3:0]                  bitCnt;
    logic [TIMER_W-1:0]          timer;

    logic syncClk;
    logic clkFall;
    logic syncData;
    logic unusedDataFall;
    logic watching;
    logic timedOut;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uClkSync (
        .Clock (Clock),
        .Reset (Reset),
        .iLine (clk_kb),
        .oLine (syncClk),
        .oFall (clkFall)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uDataSync (
        .Clock (Clock),
        .Reset (Reset),
        .iLine (data_kb),
        .oLine (syncData),
        .oFall (unusedDataFall)
    );

    assign watching = (state == ST_SEND) || (state == ST_WAIT_ACK) || (state == ST_WAIT_IDLE);
    assign timedOut = (timer == TIMEOUT_LAST);

    // NOTE: every register here is sequential state, so all updates use <=; a blocking
    // assignment would let later branches see half-updated values within the same edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            shiftReg     <= '0;
            bitCnt       <= '0;
            timer        <= '0;
            oClk_kb_low  <= 1'b0;
            oData_kb_low <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oError       <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            // A device edge in the expiry cycle wins: the abort needs a quiet cycle.
            if (watching && !clkFall && timedOut) begin
                oClk_kb_low  <= 1'b0;
                oData_kb_low <= 1'b0;
                oBusy        <= 1'b0;
                oError       <= 1'b1;
                state        <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (iStart) begin
                            shiftReg     <= {1'b1, ~^iData, iData};
                            timer        <= '0;
                            oBusy        <= 1'b1;
                            oClk_kb_low  <= 1'b1;
                            oData_kb_low <= 1'b0;
                            state        <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (timer == INHIBIT_LAST) begin
                            timer        <= '0;
                            oData_kb_low <= 1'b1;
                            state        <= ST_RTS;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_RTS: begin
                        if (timer == RTS_LAST) begin
                            timer       <= '0;
                            bitCnt      <= '0;
                            oClk_kb_low <= 1'b0;
                            state       <= ST_SEND;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (clkFall) begin
                            timer        <= '0;
                            oData_kb_low <= ~shiftReg[0];
                            shiftReg     <= shiftReg >> 1;
                            bitCnt       <= bitCnt + 1'b1;
                            if (bitCnt == LAST_BIT) begin
                                state <= ST_WAIT_ACK;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (clkFall) begin
                            timer <= '0;
                            if (syncData == PS2_ACK) begin
                                state <= ST_WAIT_IDLE;
                            end else begin
                                oError <= 1'b1;
                                oBusy  <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (syncClk && syncData) begin
                            oDone <= 1'b1;
                            oBusy <= 1'b0;
                            state <= ST_IDLE;
                        end else if (clkFall) begin
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on pulled-up open-drain lines, with a
// scoreboard of expected frames checked against what the device captures.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 8;
    localparam int RTS     = 4;
    localparam int TIMEOUT = 200;
    localparam int SYNC    = 2;
    localparam int HALF    = 10;
    localparam int M_ACK     = 0;
    localparam int M_NOACK   = 1;
    localparam int M_TIMEOUT = 2;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] iData;
    logic       iStart;
    logic       clk_kb;
    logic       data_kb;
    logic       oClk_kb_low;
    logic       oData_kb_low;
    logic       oBusy;
    logic       oDone;
    logic       oError;

    logic devClkLow  = 1'b0;
    logic devDataLow = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int doneCnt = 0;
    int errCnt  = 0;
    logic [10:0] sbQ[$];
    logic prevDataLow;
    logic resetAtEdge;

    // Open-drain lines with pull-ups: low if anyone pulls.
    assign clk_kb  = ~(oClk_kb_low | devClkLow);
    assign data_kb = ~(oData_kb_low | devDataLow);

    always #5 Clock = ~Clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iData        (iData),
        .iStart       (iStart),
        .clk_kb       (clk_kb),
        .data_kb      (data_kb),
        .oClk_kb_low  (oClk_kb_low),
        .oData_kb_low (oData_kb_low),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oError       (oError)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge Clock) resetAtEdge <= Reset;

    // Pulse accounting and line-discipline monitor.
    always @(negedge Clock) begin
        if (resetAtEdge === 1'b0) begin
            if (oDone) doneCnt++;
            if (oError) errCnt++;
            if (oDone || oError) begin
                check("pulseExclusive", 32'(oDone & oError), 0);
                check("busyAtPulse", 32'(oBusy), 0);
            end
            if (oData_kb_low !== prevDataLow && !oError)
                check("dataChangeWhileClkLow", 32'(clk_kb), 0);
        end
        prevDataLow = oData_kb_low;
    end

    task automatic startXfer(input string name, input logic [7:0] d);
        int inh;
        int rts;
        sbQ.push_back({1'b1, ~^d, d, 1'b0});
        iData  = d;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        check({name, ".busyAfterStart"}, 32'(oBusy), 1);
        inh = 0;
        while (oClk_kb_low && !oData_kb_low && inh < 100) begin
            inh++;
            @(negedge Clock);
        end
        rts = 0;
        while (oClk_kb_low && oData_kb_low && rts < 100) begin
            rts++;
            @(negedge Clock);
        end
        check({name, ".inhibitCycles"}, inh, INHIBIT);
        check({name, ".rtsCycles"}, rts, RTS);
        check({name, ".linesAtSend"}, {30'd0, clk_kb, data_kb}, 32'b10);
    endtask

    task automatic deviceFrame(input int stopAfter, input bit giveAck, input bit midStart,
                               output logic [10:0] cap, output int errAt);
        cap   = '0;
        errAt = -1;
        repeat (5) @(negedge Clock);
        cap[0] = data_kb;
        for (int k = 1; k <= 10; k++) begin
            devClkLow = 1'b1;
            if (k == stopAfter) begin
                for (int i = 1; i <= 400; i++) begin
                    @(negedge Clock);
                    if (i == HALF) begin
                        devClkLow = 1'b0;
                        cap[k]    = data_kb;
                    end
                    if (oError) begin
                        errAt = i;
                        break;
                    end
                end
                devClkLow = 1'b0;
                return;
            end
            if (midStart && k == 5) begin
                @(negedge Clock);
                iData  = CMD_RESET;
                iStart = 1'b1;
                @(negedge Clock);
                iStart = 1'b0;
                repeat (HALF - 2) @(negedge Clock);
            end else begin
                repeat (HALF) @(negedge Clock);
            end
            devClkLow = 1'b0;
            cap[k]    = data_kb;
            repeat (HALF) @(negedge Clock);
        end
        if (giveAck) devDataLow = 1'b1;
        @(negedge Clock);
        devClkLow = 1'b1;
        repeat (HALF) @(negedge Clock);
        devClkLow = 1'b0;
        repeat (2) @(negedge Clock);
        devDataLow = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (oBusy !== 1'b0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (oBusy !== 1'b0) check({name, ".idleBound"}, 1, 0);
        repeat (2) @(negedge Clock);
    endtask

    task automatic runFrame(input string name, input logic [7:0] d, input logic expParity,
                            input int mode, input bit midStart);
        logic [10:0] cap;
        logic [10:0] exp;
        logic [10:0] mask;
        int errAt;
        int done0;
        int err0;
        int stopAfter;
        done0     = doneCnt;
        err0      = errCnt;
        stopAfter = (mode == M_TIMEOUT) ? 4 : 0;
        startXfer(name, d);
        deviceFrame(stopAfter, mode == M_ACK, midStart, cap, errAt);
        waitIdle(name);
        mask = (stopAfter == 0) ? 11'h7FF : 11'((1 << (stopAfter + 1)) - 1);
        if (sbQ.size() == 0) begin
            check({name, ".scoreboardEmpty"}, 1, 0);
        end else begin
            exp = sbQ.pop_front();
            check({name, ".frame"}, 32'(cap & mask), 32'(exp & mask));
        end
        if (stopAfter == 0) check({name, ".parity"}, 32'(cap[9]), 32'(expParity));
        // The edge reaches the FSM SYNC+1 cycles after the pad changes.
        if (mode == M_TIMEOUT) check({name, ".timeoutAt"}, errAt, TIMEOUT + SYNC + 1);
        check({name, ".doneCount"}, doneCnt - done0, (mode == M_ACK) ? 1 : 0);
        check({name, ".errorCount"}, errCnt - err0, (mode == M_ACK) ? 0 : 1);
        check({name, ".busyEnd"}, 32'(oBusy), 0);
        check({name, ".linesReleased"}, {30'd0, oClk_kb_low, oData_kb_low}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        logic quiet;
        logic [10:0] dummy;
        int done0;
        int err0;

        Reset  = 1'b1;
        iStart = 1'b0;
        iData  = 8'h00;
        repeat (3) @(negedge Clock);
        check("reset.outputs", {27'd0, oClk_kb_low, oData_kb_low, oBusy, oDone, oError}, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("idle.busy", 32'(oBusy), 0);

        runFrame("t1.setLeds", CMD_SET_LEDS, 1'b1, M_ACK, 1'b0);
        runFrame("t2.byte01", 8'h01, 1'b0, M_ACK, 1'b0);
        runFrame("t2.byte00", 8'h00, 1'b1, M_ACK, 1'b0);
        runFrame("t3.noAck", 8'hA5, 1'b1, M_NOACK, 1'b0);
        runFrame("t4.timeout", 8'h3C, 1'b1, M_TIMEOUT, 1'b0);

        runFrame("t5.midStart", CMD_SET_LEDS, 1'b1, M_ACK, 1'b1);
        quiet = 1'b1;
        repeat (30) begin
            @(negedge Clock);
            if (oBusy || oClk_kb_low) quiet = 1'b0;
        end
        check("t5.noQueuedStart", 32'(quiet), 1);
        runFrame("t5.resetCmd", CMD_RESET, 1'b1, M_ACK, 1'b0);

        // Reset in the middle of the data bits.
        done0 = doneCnt;
        err0  = errCnt;
        startXfer("t6.abandoned", 8'h5A);
        repeat (5) @(negedge Clock);
        for (int k = 0; k < 3; k++) begin
            devClkLow = 1'b1;
            repeat (HALF) @(negedge Clock);
            devClkLow = 1'b0;
            repeat (HALF) @(negedge Clock);
        end
        devClkLow = 1'b1;
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("t6.afterReset", {27'd0, oClk_kb_low, oData_kb_low, oBusy, oDone, oError}, 0);
        repeat (3) @(negedge Clock);
        devClkLow = 1'b0;
        repeat (HALF) @(negedge Clock);
        check("t6.noPulses", (doneCnt - done0) + (errCnt - err0), 0);
        check("t6.stillIdle", 32'(oBusy), 0);
        if (sbQ.size() != 0) dummy = sbQ.pop_front();
        runFrame("t6.restart", 8'hC3, 1'b1, M_ACK, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs followed by the LED mask. It is the outbound counterpart of the keyboard receive path that feeds Module_VGA_Control. It shares the clk_kb/data_kb open-drain lines with that receiver. It performs the inhibit, request-to-send, device-clocked serialisation, ACK check and timeout.

Parameters:
INHIBIT_CYCLES, 5000, Clock cycles clk_kb is held low before request-to-send (100 us at 50 MHz).
RTS_CYCLES, 50, Cycles with both lines held low before clk_kb is released.
TIMEOUT_CYCLES, 750000, Maximum cycles between expected device clock edges (15 ms) before an abort.
SYNC_STAGES, 2, Synchroniser depth on clk_kb and data_kb (minimum 2).

Ports:
Clock  input  1  system clock; the only clock in the block
Reset  input  1  synchronous, active-high reset
iData  input  8  byte to send; sampled on an accepted iStart
iStart  input  1  one-cycle request; accepted only while oBusy=0
clk_kb  input  1  PS/2 clock line as read from the pad
data_kb  input  1  PS/2 data line as read from the pad
oClk_kb_low  output  1  1 = pull clk_kb low; 0 = release it (top level drives 1'bz)
oData_kb_low  output  1  1 = pull data_kb low; 0 = release it
oBusy  output  1  high from an accepted start until oDone/oError
oDone  output  1  one-cycle pulse: device ACK received and the bus has returned to idle
oError  output  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Reset (sync, active-high, any state): state=IDLE; all outputs 0, so both lines are released. The bit counter, timer and shift register are cleared. A transfer in progress is abandoned with no oDone/oError.
- clk_kb and data_kb each pass through SYNC_STAGES flops. A falling edge (fe) is the synced previous value 1 and current value 0.
- States: IDLE, INHIBIT, RTS, SEND, WAIT_ACK, WAIT_IDLE.
- IDLE:
  - On iStart, latch {stop=1, parity=~^iData, iData} into the shift register. Set oBusy=1 on the next cycle and go to INHIBIT.
  - iStart while oBusy=1 is ignored and is not queued.
- INHIBIT: oClk_kb_low=1, oData_kb_low=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: oClk_kb_low=1, oData_kb_low=1 (start bit) for RTS_CYCLES cycles. Then set oClk_kb_low=0, go to SEND and clear the bit counter.
- SEND:
  - On each fe, drive the next frame bit onto data (oData_kb_low = ~bit).
  - Falling edges 1-8 carry data LSB first, edge 9 carries parity, edge 10 carries stop (data released).
  - After edge 10, go to WAIT_ACK.
- WAIT_ACK: on the 11th fe, sample synced data_kb. A 0 is an ACK: go to WAIT_IDLE. A 1 means no ACK: pulse oError and go to IDLE.
- WAIT_IDLE: once synced clk_kb=1 and data_kb=1 on the same cycle, pulse oDone, clear oBusy and go to IDLE.
- Timeout:
  - In SEND, WAIT_ACK and WAIT_IDLE, a timer restarts on entry and on every fe.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse oError, clear oBusy, go to IDLE.
  - The first device edge after RTS gets the same TIMEOUT_CYCLES budget.
- oDone and oError are never high together. oBusy falls on the same cycle as either pulse.
- Data may only change in the cycle after an fe, while the device clock is low. Data never changes on a rising edge.
- The block never drives either line high.
- An fe arriving in the same cycle as a timeout expiry: the fe wins and the timer restarts.

Decomposition:
- Shared package ps2_pkg:
  - state enum;
  - PS2_FRAME_BITS=11;
  - PS2_ACK=1'b0;
  - command constants CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_RESET=8'hFF.
- One sub-module, ps2_line_sync: SYNC_STAGES synchroniser plus falling-edge detector for one line. It is instantiated twice here and is reusable by the receiver.
- Counters (timer, bit index) stay inline.

Test Plan:
All scenarios use INHIBIT_CYCLES=8, RTS_CYCLES=4, TIMEOUT_CYCLES=200, with a bench PS/2 device model (20-cycle device clock period) and pull-ups.
1. iStart with iData=8'hED:
   - clk_kb is low for exactly 8 cycles, then data is low and clk is released after 4 more cycles.
   - The model reads start=0, data 1,0,1,1,0,1,1,1 (LSB first), parity=1, stop=1.
   - The model ACKs; oDone pulses once, oBusy drops, oError=0.
2. iData=8'h01 -> model captures parity=0. iData=8'h00 -> parity=1. Both end with oDone.
3. Model holds data high on the 11th edge (no ACK) -> oError pulses one cycle, oDone stays 0, both lines are released.
4. Model stops clocking after edge 4 -> oError pulses exactly 200 cycles after edge 4; state returns to IDLE.
5. Second iStart (8'hFF) mid-frame:
   - The second start is ignored; the frame carries only the first byte.
   - The next iStart after oDone sends 8'hFF with parity=1.
6. Reset asserted during SEND -> the next cycle has oClk_kb_low=0, oData_kb_low=0, oBusy=0, no pulses; a new iStart works normally.
